// File: rtl/if_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : if_fetch_queue_pkg
// Brief  : Shared widths, NOP encoding and PC defaults for the fetch front end.
// Rev    : 1.0
// ============================================================================
package if_fetch_queue_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_DATA_W = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_DATA_W-1:0] inst_t;

  localparam inst_t      INST_NOP     = 32'h0000_0000;
  localparam int         PC_STEP      = 4;
  localparam inst_addr_t RESET_PC_DEF = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/if_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module : if_fetch_queue_if
// Brief  : ROM request/response and ID-stage handshake bundle for the fetch queue.
// Rev    : 1.0
// ============================================================================
interface if_fetch_queue_if
  import if_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int INST_W = INST_DATA_W
);

  logic [INST_W-1:0] rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_valid;

  // master = fetch unit, slave = ROM plus ID stage
  modport master (
    input  rom_data, stall, redirect_valid, redirect_pc,
    output rom_addr, rom_en, id_pc, id_inst, id_valid
  );

  modport slave (
    output rom_data, stall, redirect_valid, redirect_pc,
    input  rom_addr, rom_en, id_pc, id_inst, id_valid
  );

endinterface
`default_nettype wire

// File: rtl/if_fetch_queue_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : fetch_fifo
// Brief  : Synchronous FIFO with flush, holding {pc, inst} fetch entries.
// Rev    : 1.0
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic                         i_push,
  input  wire logic                         i_pop,
  input  wire logic                         i_flush,
  input  wire logic [WIDTH-1:0]             i_data,
  output logic      [WIDTH-1:0]             o_head,
  output logic      [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                              o_empty,
  output logic                              o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers are power-of-two sized, so increments wrap on their own
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : if_fetch_queue
// Brief  : Credit-based sequential instruction fetch with redirect/flush queue.
// Rev    : 1.0
// ============================================================================
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_W,
  parameter int                INST_W   = INST_DATA_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  wire logic         clk,
  input  wire logic         rst,
  if_fetch_queue_if.master  bus
);

  localparam int ENT_W = ADDR_W + INST_W;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int CRD_W = CNT_W + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_inflight;
  logic              r_kill;

  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_full;
  logic [ENT_W-1:0]  w_head;
  logic              w_id_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [CRD_W-1:0]  w_used;

  assign w_id_valid = !rst && !w_empty && !bus.redirect_valid;
  assign w_pop      = w_id_valid && !bus.stall;
  // Entries held plus the one outstanding request, less the one leaving now
  assign w_used     = CRD_W'(w_count) + CRD_W'(r_inflight) - CRD_W'(w_pop);
  assign w_issue    = !rst && !bus.redirect_valid && (w_used < CRD_W'(DEPTH));
  assign w_push     = r_inflight && !r_kill && !bus.redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_kill     <= bus.redirect_valid;
      if (w_issue) begin
        r_req_pc <= r_fetch_pc;
      end
      if (bus.redirect_valid) begin
        r_fetch_pc <= bus.redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_data  ({r_req_pc, bus.rom_data}),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign bus.rom_addr = r_fetch_pc;
  assign bus.rom_en   = w_issue;
  assign bus.id_valid = w_id_valid;
  assign bus.id_pc    = w_empty ? '0 : w_head[ENT_W-1:INST_W];
  assign bus.id_inst  = w_empty ? INST_W'(INST_NOP) : w_head[INST_W-1:0];

  logic w_unused;
  assign w_unused = w_full;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_if_fetch_queue
// Brief  : Randomized and directed checks of if_fetch_queue against a queue model.
// Rev    : 1.0
// ============================================================================
module tb_if_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.ADDR_W(32), .INST_W(32)) bus ();

  if_fetch_queue #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom_f(bus.rom_addr);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: fetch pointer, buffered PCs, outstanding request
  logic [31:0] m_fpc = RESET_PC;
  logic [31:0] m_q[$];
  bit          m_infl = 0;
  logic [31:0] m_ipc = '0;
  logic [31:0] exp_next = RESET_PC;

  logic        obs_en, obs_valid;
  logic [31:0] obs_addr, obs_pc;

  task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc, input logic r);
    bit          e_valid, e_pop, e_en;
    logic [31:0] e_pc, e_inst;
    int          used;
    bus.stall          = st;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    rst                = r;
    e_valid = !r && (m_q.size() > 0) && !rd;
    e_pop   = e_valid && !st;
    used    = m_q.size() + int'(m_infl) - int'(e_pop);
    e_en    = !r && !rd && (used < DEPTH);
    e_pc    = (m_q.size() > 0) ? m_q[0] : 32'h0;
    e_inst  = (m_q.size() > 0) ? rom_f(m_q[0]) : 32'h0;

    @(negedge clk);
    obs_en    = bus.rom_en;
    obs_valid = bus.id_valid;
    obs_addr  = bus.rom_addr;
    obs_pc    = bus.id_pc;
    chk("rom_en", {31'b0, obs_en}, {31'b0, e_en});
    chk("id_valid", {31'b0, obs_valid}, {31'b0, e_valid});
    if (!r) begin
      chk("rom_addr", obs_addr, m_fpc);
      chk("id_pc", obs_pc, e_pc);
      chk("id_inst", bus.id_inst, e_inst);
      chk("count_le_depth", {31'b0, (32'(dut.u_fifo.o_count) <= DEPTH)}, 32'h1);
      if (obs_valid && !st) begin
        chk("seq_pc", obs_pc, exp_next);
        exp_next = exp_next + 32'd4;
      end
    end

    if (r) begin
      m_fpc = RESET_PC; m_q.delete(); m_infl = 0; exp_next = RESET_PC;
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (rd) m_q.delete();
      else if (m_infl) m_q.push_back(m_ipc);
      m_infl = e_en;
      if (e_en) m_ipc = m_fpc;
      if (rd) begin
        m_fpc = rpc; exp_next = rpc;
      end else if (e_en) begin
        m_fpc = m_fpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;

    // Reset then free-running stream
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rst_en", {31'b0, obs_en}, 32'h0);
    cyc(0, 0, 0, 0);
    chk("c0_en", {31'b0, obs_en}, 32'h1);
    chk("c0_addr", obs_addr, 32'h0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("c2_valid", {31'b0, obs_valid}, 32'h1);
    chk("c2_pc", obs_pc, 32'h0);
    cyc(0, 0, 0, 0);
    chk("c3_pc", obs_pc, 32'h4);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);

    // Stall from reset until full, then release
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("full_en", {31'b0, obs_en}, 32'h0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rel_pc0", obs_pc, 32'h0);
    chk("rel_en", {31'b0, obs_en}, 32'h1);
    chk("rel_addr", obs_addr, 32'h10);
    cyc(0, 0, 0, 0); chk("rel_pc1", obs_pc, 32'h4);
    cyc(0, 0, 0, 0); chk("rel_pc2", obs_pc, 32'h8);
    cyc(0, 0, 0, 0); chk("rel_pc3", obs_pc, 32'hC);

    // Redirect while streaming
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h100, 0);
    chk("R_valid", {31'b0, obs_valid}, 32'h0);
    cyc(0, 0, 0, 0);
    chk("R1_en", {31'b0, obs_en}, 32'h1);
    chk("R1_addr", obs_addr, 32'h100);
    chk("R1_valid", {31'b0, obs_valid}, 32'h0);
    cyc(0, 0, 0, 0);
    chk("R2_valid", {31'b0, obs_valid}, 32'h0);
    cyc(0, 0, 0, 0);
    chk("R3_valid", {31'b0, obs_valid}, 32'h1);
    chk("R3_pc", obs_pc, 32'h100);

    // Redirect under stall with three queued and a response returning
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 32'h200, 0);
    chk("RS_valid", {31'b0, obs_valid}, 32'h0);
    cyc(0, 0, 0, 0);
    chk("RS1_addr", obs_addr, 32'h200);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("RS3_pc", obs_pc, 32'h200);

    // Random stall/redirect traffic, including an address wrap
    for (int i = 0; i < 200; i++) begin
      logic        st, rd;
      logic [31:0] rpc;
      st  = ($urandom % 3) == 0;
      rd  = ($urandom % 25) == 0;
      rpc = $urandom & 32'hFFFF_FFFC;
      if (i == 100) begin rd = 1'b1; rpc = 32'hFFFF_FFF8; end
      cyc(st, rd, rpc, 0);
    end

    // Reset mid-stream with three entries buffered
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    chk("pre_rst_cnt", 32'(dut.u_fifo.o_count), 32'd3);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("post_rst_valid", {31'b0, obs_valid}, 32'h0);
    chk("post_rst_cnt", 32'(dut.u_fifo.o_count), 32'd0);
    chk("post_rst_addr", obs_addr, RESET_PC);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
